// File: rtl/spi_mem_slave_param_if.sv
// SPI slave pins of the memory subsystem, grouped as one interface.
// The slave modport is the RAM side; the master modport is the host side.
interface spi_mem_slave_param_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_err;

    modport slave  (input SS_n, input MOSI, output MISO, output busy, output frame_err);
    modport master (output SS_n, output MOSI, input MISO, input busy, input frame_err);
endinterface

// File: rtl/spi_mem_slave_param.sv
// Parametrised SPI slave with an internal single-port RAM.
// A frame is 2 command bits followed by DATA_WIDTH payload bits, MSB first.
// Exactly one command is executed per SS_n-low window.
// Separate write and read pointers are kept, with optional auto-increment.
module spi_mem_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_mem_slave_param_if.slave spi
);
    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int RX_LAST = FRAME_W - 1;
    localparam int TX_LAST = DATA_WIDTH - 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = MEM_DEPTH[ADDR_WIDTH:0];

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RX   = 3'd1,
        ST_EXEC = 3'd2,
        ST_TX   = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [CNT_W-1:0]        tx_cnt_r;
    logic [FRAME_W-1:0]      rx_shift_r;
    logic [DATA_WIDTH-1:0]   tx_shift_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r;
    logic                    miso_r;
    logic                    busy_r;
    logic                    frame_err_r;
    logic                    frame_err_s;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [1:0]              cmd_s;
    logic [DATA_WIDTH-1:0]   payload_s;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // A pointer addresses real storage only below MEM_DEPTH.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] ptr);
        return ({1'b0, ptr} < DEPTH_C);
    endfunction

    // Post-access pointer value: wraps at the top of RAM, and an out-of-range pointer restarts at 0.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        logic [ADDR_WIDTH-1:0] nxt;
        if (AUTO_INC == 0) begin
            nxt = ptr;
        end else if (!in_range(ptr)) begin
            nxt = '0;
        end else if ({1'b0, ptr} == (DEPTH_C - 1'b1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + 1'b1;
        end
        return nxt;
    endfunction

    assign cmd_s     = rx_shift_r[FRAME_W-1 -: 2];
    assign payload_s = rx_shift_r[DATA_WIDTH-1:0];

    // Read port view: out-of-range reads return an all-zero word.
    always_comb begin
        rd_word_s = '0;
        if (in_range(rd_ptr_r)) begin
            rd_word_s = mem[rd_ptr_r];
        end else begin
            rd_word_s = '0;
        end
    end

    // Write strobe for the EXEC cycle of an in-range WR_DATA.
    always_comb begin
        mem_we_s = 1'b0;
        if ((state_r == ST_EXEC) && (cmd_s == CMD_WR_DATA) && in_range(wr_ptr_r)) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Next-state decode; SS_n high always returns to IDLE, and in RX it flags an aborted frame.
    always_comb begin
        next_state_s = state_r;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!spi.SS_n) next_state_s = ST_RX;
                else           next_state_s = ST_IDLE;
            end
            ST_RX: begin
                if (spi.SS_n) begin
                    next_state_s = ST_IDLE;
                    frame_err_s  = 1'b1;
                end else if (bit_cnt_r == RX_LAST[CNT_W-1:0]) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_RX;
                end
            end
            ST_EXEC: begin
                if (spi.SS_n)                  next_state_s = ST_IDLE;
                else if (cmd_s == CMD_RD_DATA) next_state_s = ST_TX;
                else                           next_state_s = ST_WAIT;
            end
            ST_TX: begin
                if (spi.SS_n)                                 next_state_s = ST_IDLE;
                else if (tx_cnt_r == TX_LAST[CNT_W-1:0])      next_state_s = ST_WAIT;
                else                                          next_state_s = ST_TX;
            end
            ST_WAIT: begin
                if (spi.SS_n) next_state_s = ST_IDLE;
                else          next_state_s = ST_WAIT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the shift/pointer datapath and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= '0;
            tx_cnt_r    <= '0;
            rx_shift_r  <= '0;
            tx_shift_r  <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != ST_IDLE);
            frame_err_r <= frame_err_s;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= '0;
                    miso_r    <= 1'b0;
                end
                ST_RX: begin
                    rx_shift_r <= {rx_shift_r[FRAME_W-2:0], spi.MOSI};
                    bit_cnt_r  <= bit_cnt_r + 1'b1;
                end
                ST_EXEC: begin
                    tx_cnt_r <= '0;
                    miso_r   <= 1'b0;
                    case (cmd_s)
                        CMD_WR_ADDR: wr_ptr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_WR_DATA: wr_ptr_r <= next_ptr(wr_ptr_r);
                        CMD_RD_ADDR: rd_ptr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_RD_DATA: begin
                            rd_ptr_r <= next_ptr(rd_ptr_r);
                            if (!spi.SS_n) begin
                                miso_r     <= rd_word_s[DATA_WIDTH-1];
                                tx_shift_r <= {rd_word_s[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                        default: begin
                            miso_r <= 1'b0;
                        end
                    endcase
                end
                ST_TX: begin
                    if (spi.SS_n || (tx_cnt_r == TX_LAST[CNT_W-1:0])) begin
                        miso_r <= 1'b0;
                    end else begin
                        miso_r     <= tx_shift_r[DATA_WIDTH-1];
                        tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        tx_cnt_r   <= tx_cnt_r + 1'b1;
                    end
                end
                ST_WAIT: begin
                    miso_r <= 1'b0;
                end
                default: begin
                    miso_r <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port; contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_ptr_r] <= payload_s;
        end
    end

    assign spi.MISO      = miso_r;
    assign spi.busy      = busy_r;
    assign spi.frame_err = frame_err_r;
endmodule
